pipe_stage_fifo: RTL and testbench
==================================

Name: pipe_stage_fifo

Overview:
- Parametrised successor to the fixed fetch/decode latch: a DEPTH-entry in-order buffer between two pipeline stages, carrying an instruction word plus its PC+4.
- Uses a valid/ready handshake on both sides, so fetch can run ahead of a stalled decode.
- Supports synchronous flush for branch/jump squash.
- Empty or flushed output presents an all-zero payload, which is the NOP bubble.

Parameters:
- INSTR_W, 32, instruction payload width in bits.
- PC_W, 32, PC+4 payload width in bits.
- DEPTH, 2, number of buffer entries; legal range 1..8; need not be a power of two.
- READY_BYPASS, 1, when 1, in_ready is also asserted while full if out_ready=1 (same-cycle pop frees a slot); when 0, in_ready = !full.

Ports:
- CLK  input  1  single clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- flush  input  1  discard all entries this edge.
- in_valid  input  1  upstream has a word (fetch iHit qualified).
- in_ready  output  1  buffer accepts the word this cycle.
- in_instr  input  INSTR_W  instruction from imemload.
- in_pcp4  input  PC_W  PC+4 of that instruction.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  downstream consumes the head this cycle (decode not stalled).
- out_instr  output  INSTR_W  head instruction; 0 when empty.
- out_pcp4  output  PC_W  head PC+4; 0 when empty.
- count  output  $clog2(DEPTH+1)  current occupancy.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset: RST is sampled on the CLK edge only; it is synchronous, with no asynchronous path.
  - Read pointer, write pointer and count go to 0; all storage entries go to 0.
  - After reset: out_valid=0, out_instr=0, out_pcp4=0, empty=1, full=0.
  - in_ready=1 after reset, for any DEPTH>=1.
- Push: push = in_valid && in_ready. Entry written at the write pointer on the edge.
- Pop: pop = out_valid && out_ready. Read pointer advances on the edge.
- Pointers increment modulo DEPTH (explicit wrap compare at DEPTH-1, not bit truncation).
- Count: count_next = count + push - pop.
  - Simultaneous push and pop leaves count unchanged; both pointers advance.
- Latency: a word pushed at edge N is visible on the outputs after edge N (out_valid=1 in cycle N+1). There is no combinational in->out path.
- Outputs are driven from the storage entry at the read pointer.
  - out_valid = !empty.
  - Payload is forced to 0 when empty, so stale data is never visible.
- in_ready:
  - READY_BYPASS=0: in_ready = !full.
  - READY_BYPASS=1: in_ready = !full || out_ready.
  - in_ready must not depend on in_valid.
- Full with READY_BYPASS=1 and out_ready=1: push and pop both occur and count stays DEPTH.
- Full with out_ready=0: in_ready=0; upstream must hold its data stable.
- Empty with in_valid=1 and out_ready=1: no pop (out_valid=0). Push occurs and the word appears in the next cycle.
- Flush has priority over push and pop in the same cycle.
  - Pointers and count go to 0; the incoming word is dropped.
  - Storage contents need not be cleared, because the empty output masking yields zeros.
- RST has priority over flush.
- in_ready and out_ready are evaluated normally while flush is asserted, but no state change occurs other than the clear.
- Reset mid-stream: all buffered words are lost and the outputs read 0 from the next cycle.
- Assertions (simulation only):
  - count <= DEPTH.
  - No push when full unless a pop occurs in the same cycle.
  - in_instr and in_pcp4 stable while in_valid && !in_ready.

Decomposition:
- cpu_types_pkg: add typedef pipe_payload_t (packed struct {word_t instr; word_t pcp4;}) for the default-width instance.
  - Add constant PIPE_FIFO_DEPTH_DEF = 2.
- Add modport-style interface pipe_stage_fifo_if in the team's interface header (signals above, modports fifo and tb).
- One sub-module: pipe_ptr_ctr, a modulo-DEPTH pointer counter with inc and clr inputs, instantiated twice (read and write).

Test Plan:
- Reset and idle: hold RST=1 for 2 cycles with in_valid=1 and in_instr=0xDEADBEEF. Required: count=0, out_valid=0, out_instr=0, in_ready=1.
- Fill to full, DEPTH=2, out_ready=0: push 0x11111111/pcp4 0x4, then 0x22222222/0x8. Required: full=1, in_ready=0 (READY_BYPASS=0), out_instr=0x11111111, out_pcp4=0x4.
- Drain in order: then raise out_ready. Required: out_instr 0x11111111 then 0x22222222 on successive cycles, then out_valid=0, out_instr=0, empty=1.
- Full with bypass, READY_BYPASS=1, DEPTH=2: hold out_ready=1 and stream 0x100..0x10F continuously. Required:
  - in_ready never drops.
  - count settles at 1 (stays 1 every cycle while streaming; never reaches 2 since each push is matched by a pop).
  - Outputs arrive in order with 1-cycle latency.
  - Pointers wrap cleanly.
- Flush collision: with count=2, assert flush together with in_valid=1 (0x33333333) and out_ready=1. Required: next cycle count=0, out_valid=0, and 0x33333333 is never output.
- Non-power-of-two wrap, DEPTH=3: interleave 10 pushes and pops with random out_ready. Required: output order matches input order exactly, count never exceeds 3, and the 4th push lands in entry 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types and constants used by the pipeline buffer.
package cpu_types_pkg;
    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        word_t instr;
        word_t pcp4;
    } pipe_payload_t;

    localparam int PIPE_FIFO_DEPTH_DEF = 2;

    // A one-entry buffer still needs a 1-bit pointer to stay a legal vector.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/pipe_stage_fifo_if.sv
// Bundle of the fetch/decode buffer signals with FIFO-side and bench-side views.
interface pipe_stage_fifo_if
    import cpu_types_pkg::*;
#(
    parameter int INSTR_W = WORD_W,
    parameter int PC_W    = WORD_W,
    parameter int DEPTH   = PIPE_FIFO_DEPTH_DEF
) (
    input logic CLK
);
    logic                       RST;
    logic                       flush;
    logic                       in_valid;
    logic                       in_ready;
    logic [INSTR_W-1:0]         in_instr;
    logic [PC_W-1:0]            in_pcp4;
    logic                       out_valid;
    logic                       out_ready;
    logic [INSTR_W-1:0]         out_instr;
    logic [PC_W-1:0]            out_pcp4;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic                       full;
    logic                       empty;

    modport fifo (
        input  CLK, RST, flush, in_valid, in_instr, in_pcp4, out_ready,
        output in_ready, out_valid, out_instr, out_pcp4, count, full, empty
    );

    modport tb (
        input  CLK, in_ready, out_valid, out_instr, out_pcp4, count, full, empty,
        output RST, flush, in_valid, in_instr, in_pcp4, out_ready
    );
endinterface

// File: rtl/pipe_ptr_ctr.sv
// Modulo-DEPTH pointer; clear wins over increment, wrap is an explicit compare.
module pipe_ptr_ctr
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = PIPE_FIFO_DEPTH_DEF,
    parameter int PTR_W = ptr_w(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [PTR_W-1:0] ptr_o
);
    logic [PTR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;
endmodule

// File: rtl/pipe_stage_fifo.sv
// In-order fetch->decode buffer with valid/ready on both sides and branch flush.
// An empty buffer presents an all-zero payload, which decode treats as a NOP.
module pipe_stage_fifo
    import cpu_types_pkg::*;
#(
    parameter int INSTR_W      = 32,
    parameter int PC_W         = 32,
    parameter int DEPTH        = PIPE_FIFO_DEPTH_DEF,
    parameter int READY_BYPASS = 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INSTR_W-1:0]         in_instr,
    input  logic [PC_W-1:0]            in_pcp4,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [PC_W-1:0]            out_pcp4,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [INSTR_W-1:0] instr_q [DEPTH];
    logic [PC_W-1:0]    pcp4_q  [DEPTH];
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic               push, pop, wr_en;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = (READY_BYPASS != 0) ? (!full || out_ready) : !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign wr_en     = push && !flush;
    assign count     = count_q;

    pipe_ptr_ctr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
        .CLK   (CLK),
        .RST   (RST),
        .clr_i (flush),
        .inc_i (pop),
        .ptr_o (rd_ptr)
    );

    pipe_ptr_ctr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
        .CLK   (CLK),
        .RST   (RST),
        .clr_i (flush),
        .inc_i (push),
        .ptr_o (wr_ptr)
    );

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flush leaves storage dirty; the empty mask on the outputs hides it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pcp4_q[i]  <= '0;
            end
        end else if (wr_en) begin
            instr_q[wr_ptr] <= in_instr;
            pcp4_q[wr_ptr]  <= in_pcp4;
        end
    end

    assign out_instr = empty ? '0 : instr_q[rd_ptr];
    assign out_pcp4  = empty ? '0 : pcp4_q[rd_ptr];

    a_count_bound: assert property (@(posedge CLK) disable iff (RST)
        count_q <= CNT_W'(DEPTH));
    a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
        (push && full) |-> pop);
    a_in_stable: assert property (@(posedge CLK) disable iff (RST)
        (in_valid && !in_ready) |=> ($stable(in_instr) && $stable(in_pcp4)));
endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Bench for pipe_stage_fifo: three configurations checked against a queue model.
module tb_pipe_stage_fifo;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        flush_w     [3];
    logic        in_valid_w  [3];
    logic        in_ready_w  [3];
    logic [31:0] in_instr_w  [3];
    logic [31:0] in_pcp4_w   [3];
    logic        out_valid_w [3];
    logic        out_ready_w [3];
    logic [31:0] out_instr_w [3];
    logic [31:0] out_pcp4_w  [3];
    logic [1:0]  count_w     [3];
    logic        full_w      [3];
    logic        empty_w     [3];

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] mq [$];
    int          sel;
    int          depth_m;
    bit          bypass_m;

    always #5 CLK = ~CLK;

    pipe_stage_fifo #(.INSTR_W(32), .PC_W(32), .DEPTH(2), .READY_BYPASS(0)) u_dut0 (
        .CLK(CLK), .RST(RST), .flush(flush_w[0]), .in_valid(in_valid_w[0]),
        .in_ready(in_ready_w[0]), .in_instr(in_instr_w[0]), .in_pcp4(in_pcp4_w[0]),
        .out_valid(out_valid_w[0]), .out_ready(out_ready_w[0]), .out_instr(out_instr_w[0]),
        .out_pcp4(out_pcp4_w[0]), .count(count_w[0]), .full(full_w[0]), .empty(empty_w[0])
    );

    pipe_stage_fifo #(.INSTR_W(32), .PC_W(32), .DEPTH(2), .READY_BYPASS(1)) u_dut1 (
        .CLK(CLK), .RST(RST), .flush(flush_w[1]), .in_valid(in_valid_w[1]),
        .in_ready(in_ready_w[1]), .in_instr(in_instr_w[1]), .in_pcp4(in_pcp4_w[1]),
        .out_valid(out_valid_w[1]), .out_ready(out_ready_w[1]), .out_instr(out_instr_w[1]),
        .out_pcp4(out_pcp4_w[1]), .count(count_w[1]), .full(full_w[1]), .empty(empty_w[1])
    );

    pipe_stage_fifo #(.INSTR_W(32), .PC_W(32), .DEPTH(3), .READY_BYPASS(0)) u_dut2 (
        .CLK(CLK), .RST(RST), .flush(flush_w[2]), .in_valid(in_valid_w[2]),
        .in_ready(in_ready_w[2]), .in_instr(in_instr_w[2]), .in_pcp4(in_pcp4_w[2]),
        .out_valid(out_valid_w[2]), .out_ready(out_ready_w[2]), .out_instr(out_instr_w[2]),
        .out_pcp4(out_pcp4_w[2]), .count(count_w[2]), .full(full_w[2]), .empty(empty_w[2])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s (dut%0d t=%0t): got %0h expected %0h", tag, sel, $time, obs, exp);
        end
    endtask

    // One clock of stimulus on the selected instance; others idle.
    task automatic cycle(input bit rst, input bit fl, input bit iv, input logic [31:0] ii,
                         input logic [31:0] ip, input bit ordy, output bit pushed);
        bit          exp_rdy;
        bit          popped;
        int          n;
        logic [63:0] head;
        for (int k = 0; k < 3; k++) begin
            flush_w[k]     = (k == sel) ? fl : 1'b0;
            in_valid_w[k]  = (k == sel) ? iv : 1'b0;
            in_instr_w[k]  = (k == sel) ? ii : 32'h0;
            in_pcp4_w[k]   = (k == sel) ? ip : 32'h0;
            out_ready_w[k] = (k == sel) ? ordy : 1'b0;
        end
        RST = rst;
        #1;
        n       = mq.size();
        head    = (n != 0) ? mq[0] : 64'h0;
        exp_rdy = (n < depth_m) || (bypass_m && ordy);
        chk("in_ready",  64'(in_ready_w[sel]),  64'(exp_rdy));
        chk("out_valid", 64'(out_valid_w[sel]), 64'(n != 0));
        chk("out_instr", 64'(out_instr_w[sel]), 64'(head[63:32]));
        chk("out_pcp4",  64'(out_pcp4_w[sel]),  64'(head[31:0]));
        chk("count",     64'(count_w[sel]),     64'(n));
        chk("full",      64'(full_w[sel]),      64'(n == depth_m));
        chk("empty",     64'(empty_w[sel]),     64'(n == 0));
        pushed = iv && exp_rdy && !rst && !fl;
        popped = (n != 0) && ordy;
        @(posedge CLK);
        #1;
        if (rst || fl) begin
            mq.delete();
        end else begin
            if (popped) void'(mq.pop_front());
            if (pushed) mq.push_back({ii, ip});
        end
    endtask

    task automatic start_phase(input int s, input int d, input bit b);
        bit p;
        sel      = s;
        depth_m  = d;
        bypass_m = b;
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, p);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit          p;
        bit          pend;
        bit          ivv;
        bit          fl;
        bit          rst;
        bit          ordy;
        int          push_cnt;
        logic [31:0] pi, pp;

        for (int k = 0; k < 3; k++) begin
            flush_w[k] = 1'b0; in_valid_w[k] = 1'b0; out_ready_w[k] = 1'b0;
            in_instr_w[k] = 32'h0; in_pcp4_w[k] = 32'h0;
        end
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        // Reset held with a word offered, then the plain idle state.
        sel = 0; depth_m = 2; bypass_m = 1'b0;
        repeat (2) cycle(1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 32'h1000, 1'b0, p);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, p);

        // Fill to full with decode stalled, then drain in order.
        cycle(1'b0, 1'b0, 1'b1, 32'h11111111, 32'h4, 1'b0, p);
        cycle(1'b0, 1'b0, 1'b1, 32'h22222222, 32'h8, 1'b0, p);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, p);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, p);

        // Bypass instance: continuous streaming with decode always ready.
        start_phase(1, 2, 1'b1);
        for (int i = 0; i < 16; i++)
            cycle(1'b0, 1'b0, 1'b1, 32'h100 + 32'(i), 32'h1000 + 32'(4 * i), 1'b1, p);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, p);

        // Full with bypass: push and pop together, then flush collision.
        cycle(1'b0, 1'b0, 1'b1, 32'hA1, 32'h10, 1'b0, p);
        cycle(1'b0, 1'b0, 1'b1, 32'hA2, 32'h14, 1'b0, p);
        cycle(1'b0, 1'b0, 1'b1, 32'hA3, 32'h18, 1'b1, p);
        cycle(1'b0, 1'b1, 1'b1, 32'h33333333, 32'hC, 1'b1, p);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, p);

        // DEPTH=3 random traffic; first segment clean, second with flush and reset.
        start_phase(2, 3, 1'b0);
        pend = 1'b0; push_cnt = 0; pi = 32'h0; pp = 32'h0;
        for (int c = 0; c < 80; c++) begin
            if (!pend) begin
                ivv = ($urandom_range(0, 3) != 0);
                pi  = $urandom;
                pp  = $urandom & 32'hFFFF_FFFC;
            end else begin
                ivv = 1'b1;
            end
            ordy = ($urandom_range(0, 1) != 0);
            fl   = (c >= 40) && ($urandom_range(0, 7) == 0);
            rst  = (c == 60);
            cycle(rst, fl, ivv, pi, pp, ordy, p);
            if (p && c < 40) begin
                push_cnt++;
                if (push_cnt == 4) chk("entry0_wrap", 64'(u_dut2.instr_q[0]), 64'(pi));
            end
            pend = ivv && !p && !rst;
        end
        pend = 1'b0;
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, p);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
